// File: rtl/mii_pkg.sv
// mii_pkg
// Shared definitions for the MII receive path: the frame-checker state
// encoding, default line codes and default frame-length limits. Imported by
// mii_frame_checker and available to any other stage of the loopback chain.
package mii_pkg;

  // Frame-delineation states. The encoding is visible on the checker's
  // dbg_state output, so keep the values stable.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } mii_state_e;

  // Default line codes.
  localparam logic [7:0] PREAMBLE_CODE_DEF = 8'h55;
  localparam logic [7:0] SFD_CODE_DEF      = 8'hD5;
  localparam logic [7:0] IDLE_CODE_DEF     = 8'h00;

  // Default cycle counts: preamble octets, SFD octets, minimum payload.
  localparam int PREAMBLE_CYCLES_DEF = 7;
  localparam int SFD_CYCLES_DEF      = 1;
  localparam int MIN_DATA_DEF        = 46;
  localparam int MAX_DATA_DEF        = 1500;

  // A completed frame is good only if it carried at least one octet and its
  // length lies in [lo, hi]. The non-zero term keeps a zero-length frame bad
  // even if a caller configures lo = 0.
  function automatic logic len_in_range(input logic [15:0] len,
                                        input logic [15:0] lo,
                                        input logic [15:0] hi);
    return (len != 16'd0) && (len >= lo) && (len <= hi);
  endfunction

endpackage

// File: rtl/mii_sat_counter.sv
// mii_sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset (clears the count)
//   inc   - count one event this cycle
//   count - current count, registered
module mii_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TOP = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != TOP)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mii_frame_checker.sv
// mii_frame_checker
// Receive-side frame checker for the byte-wide MII stream of the frame
// generator. Finds preamble + SFD, forwards the payload as a valid/sof/eof
// stream, checks the payload length and keeps saturating good/bad counters.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous, active-low reset
//   rx_data[7:0] - MII octet (ignored while rx_ctrl = 1)
//   rx_ctrl      - 1 = control/idle/end-of-frame symbol, 0 = data octet
//   out_data     - payload octet
//   out_valid    - out_data valid this cycle
//   out_sof      - first payload octet of the frame (with out_valid)
//   out_eof      - last payload octet of the frame (with out_valid)
//   out_err      - frame in error (with out_eof)
//   frame_done   - one-cycle pulse at frame end
//   frame_ok     - with frame_done: length in [MIN_DATA, MAX_DATA]
//   err_preamble - pulse: bad/short/long preamble, bad SFD
//   err_length   - pulse: payload too short or too long
//   frame_cnt    - good frames, saturating
//   err_cnt      - errored frames, saturating
//   last_len     - payload length of the last completed frame
//   dbg_state    - current delineation state
//
// Output stream: out_valid qualifies out_data/out_sof/out_eof/out_err for
// exactly one cycle. There is no ready; the consumer must take every beat.
//
// Each payload octet is held for one cycle so that the beat carrying the
// last octet can be tagged with out_eof when the end symbol arrives. That
// gives a fixed one-cycle payload latency on top of the output register.
module mii_frame_checker
  import mii_pkg::*;
#(
  parameter int         PREAMBLE_CYCLES = PREAMBLE_CYCLES_DEF,
  parameter int         MIN_DATA        = MIN_DATA_DEF,
  parameter int         MAX_DATA        = MAX_DATA_DEF,
  parameter logic [7:0] PREAMBLE_CODE   = PREAMBLE_CODE_DEF,
  parameter logic [7:0] SFD_CODE        = SFD_CODE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ctrl,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_preamble,
  output logic        err_length,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] last_len,
  output mii_state_e  dbg_state
);

  localparam logic [7:0]  PRE_FULL = 8'(PREAMBLE_CYCLES);
  // One past the required count: any longer preamble reads as "too long".
  localparam logic [7:0]  PRE_SAT  = 8'(PREAMBLE_CYCLES + 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_DATA);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_DATA);

  mii_state_e  state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  // Octets accepted in the current frame. Non-zero also means the hold
  // register is occupied.
  logic [15:0] len_q, len_d;
  logic [7:0]  hold_q, hold_d;

  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        out_err_q, out_err_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic        err_pre_q, err_pre_d;
  logic        err_len_q, err_len_d;
  logic [15:0] last_len_q, last_len_d;

  logic        len_ok;
  logic        have_held;

  assign len_ok    = len_in_range(len_q, MIN_LEN, MAX_LEN);
  assign have_held = (len_q != 16'd0);

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    len_d        = len_q;
    hold_d       = hold_q;
    out_data_d   = 8'h00;
    out_valid_d  = 1'b0;
    out_sof_d    = 1'b0;
    out_eof_d    = 1'b0;
    out_err_d    = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;
    err_pre_d    = 1'b0;
    err_len_d    = 1'b0;
    last_len_d   = last_len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_ctrl) begin
          if (rx_data == PREAMBLE_CODE) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 8'd1;
          end else begin
            state_d   = ST_DROP;
            err_pre_d = 1'b1;
          end
        end
      end

      ST_PREAMBLE: begin
        if (rx_ctrl) begin
          // Frame aborted before SFD.
          state_d   = ST_IDLE;
          err_pre_d = 1'b1;
        end else if (rx_data == PREAMBLE_CODE) begin
          if (pre_cnt_q != PRE_SAT) begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end else if ((rx_data == SFD_CODE) && (pre_cnt_q == PRE_FULL)) begin
          state_d = ST_DATA;
          len_d   = 16'd0;
        end else begin
          state_d   = ST_DROP;
          err_pre_d = 1'b1;
        end
      end

      ST_DATA: begin
        if (rx_ctrl) begin
          // End of frame: flush the held octet (if any) as the eof beat.
          out_valid_d  = have_held;
          out_data_d   = have_held ? hold_q : 8'h00;
          out_sof_d    = (len_q == 16'd1);
          out_eof_d    = have_held;
          out_err_d    = have_held && !len_ok;
          frame_done_d = 1'b1;
          frame_ok_d   = len_ok;
          err_len_d    = !len_ok;
          last_len_d   = len_q;
          len_d        = 16'd0;
          state_d      = ST_IDLE;
        end else if (len_q == MAX_LEN) begin
          // One octet too many: close the frame on the held MAX_DATA-th
          // octet as errored and discard the rest until the end symbol.
          out_valid_d  = 1'b1;
          out_data_d   = hold_q;
          out_sof_d    = (len_q == 16'd1);
          out_eof_d    = 1'b1;
          out_err_d    = 1'b1;
          frame_done_d = 1'b1;
          frame_ok_d   = 1'b0;
          err_len_d    = 1'b1;
          last_len_d   = len_q;
          len_d        = 16'd0;
          state_d      = ST_DROP;
        end else begin
          hold_d = rx_data;
          len_d  = len_q + 16'd1;
          if (have_held) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            out_sof_d   = (len_q == 16'd1);
          end
        end
      end

      ST_DROP: begin
        if (rx_ctrl) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= 8'd0;
      len_q        <= 16'd0;
      hold_q       <= 8'h00;
      out_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_pre_q    <= 1'b0;
      err_len_q    <= 1'b0;
      last_len_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      out_err_q    <= out_err_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_pre_q    <= err_pre_d;
      err_len_q    <= err_len_d;
      last_len_q   <= last_len_d;
    end
  end

  // Counters run off the registered pulses, so they move one cycle later.
  // err_preamble and err_length come from different states and never
  // coincide, so OR-ing them is at most one increment per cycle.
  mii_sat_counter #(.WIDTH(16)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (frame_done_q && frame_ok_q),
    .count (frame_cnt)
  );

  mii_sat_counter #(.WIDTH(16)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_pre_q || err_len_q),
    .count (err_cnt)
  );

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_sof      = out_sof_q;
  assign out_eof      = out_eof_q;
  assign out_err      = out_err_q;
  assign frame_done   = frame_done_q;
  assign frame_ok     = frame_ok_q;
  assign err_preamble = err_pre_q;
  assign err_length   = err_len_q;
  assign last_len     = last_len_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mii_frame_checker.sv
module tb_mii_frame_checker;
  import mii_pkg::*;

  localparam int PRE_N = 7;
  localparam int MIN_D = 46;
  localparam int MAX_D = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_ctrl = 1'b1;

  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, out_err;
  logic        frame_done, frame_ok, err_preamble, err_length;
  logic [15:0] frame_cnt, err_cnt, last_len;
  mii_state_e  dbg_state;

  always #5 clk = ~clk;

  mii_frame_checker #(.MAX_DATA(MAX_D)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ctrl      (rx_ctrl),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .out_err      (out_err),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .err_preamble (err_preamble),
    .err_length   (err_length),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt),
    .last_len     (last_len),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  // Beat record: {sof, eof, err, data}
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  // Frame-end record: {frame_ok, eof beat in same cycle, last_len}
  logic [17:0] exp_done_q[$];
  logic [17:0] obs_done_q[$];
  int exp_pre_n = 0, obs_pre_n = 0;
  int exp_len_n = 0, obs_len_n = 0;
  int stray_n = 0;
  int m_frame_cnt = 0, m_err_cnt = 0;
  int beat_idx = 0, done_idx = 0;
  logic [7:0] pay [0:127];

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (out_valid) obs_q.push_back({out_sof, out_eof, out_err, out_data});
    else if (out_sof || out_eof || out_err) stray_n++;
    if (frame_done) obs_done_q.push_back({frame_ok, out_eof && out_valid, last_len});
    else if (frame_ok) stray_n++;
    if (err_preamble) obs_pre_n++;
    if (err_length) obs_len_n++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sym(input logic c, input logic [7:0] d);
    @(negedge clk);
    rx_ctrl = c;
    rx_data = d;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 128; i++) pay[i] = 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 128; i++) pay[i] = 8'($urandom_range(0, 255));
  endtask

  // Sends one frame attempt and records what the frame-level rules predict:
  // the preamble is good only as exactly PRE_N preamble octets followed by
  // the SFD; a good frame forwards min(plen, MAX_D) octets and is ok only
  // for MIN_D <= plen <= MAX_D.
  task automatic send_frame(input int pre_n, input bit has_sfd, input logic [7:0] sfd,
                            input int plen, input int gap);
    bit pre_ok, ok;
    int nb;
    logic sof_b, eof_b, err_b;
    for (int i = 0; i < pre_n; i++) drive_sym(1'b0, PREAMBLE_CODE_DEF);
    if (has_sfd) begin
      drive_sym(1'b0, sfd);
      for (int i = 0; i < plen; i++) drive_sym(1'b0, pay[i]);
    end
    drive_sym(1'b1, IDLE_CODE_DEF);
    for (int i = 0; i < gap; i++) drive_sym(1'b1, IDLE_CODE_DEF);

    pre_ok = has_sfd && (pre_n == PRE_N) && (sfd == SFD_CODE_DEF);
    if (!pre_ok) begin
      if (has_sfd || pre_n > 0) begin
        exp_pre_n++;
        m_err_cnt++;
      end
    end else begin
      nb = (plen > MAX_D) ? MAX_D : plen;
      ok = (plen >= MIN_D) && (plen <= MAX_D);
      for (int i = 0; i < nb; i++) begin
        sof_b = (i == 0);
        eof_b = (i == nb - 1);
        err_b = eof_b && !ok;
        exp_q.push_back({sof_b, eof_b, err_b, pay[i]});
      end
      exp_done_q.push_back({ok, nb > 0, 16'(nb)});
      if (ok) m_frame_cnt++;
      else begin
        exp_len_n++;
        m_err_cnt++;
      end
    end
    if (m_frame_cnt > 65535) m_frame_cnt = 65535;
    if (m_err_cnt > 65535) m_err_cnt = 65535;
  endtask

  // Let the line go idle, then compare everything recorded since last time.
  task automatic flush(input string tag);
    repeat (3) drive_sym(1'b1, IDLE_CODE_DEF);
    @(negedge clk);
    #1;
    chk({tag, "_beat_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = beat_idx; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_beat"}, 32'(obs_q[i]), 32'(exp_q[i]));
    beat_idx = exp_q.size();
    chk({tag, "_done_count"}, 32'(obs_done_q.size()), 32'(exp_done_q.size()));
    for (int i = done_idx; i < exp_done_q.size() && i < obs_done_q.size(); i++)
      chk({tag, "_done"}, 32'(obs_done_q[i]), 32'(exp_done_q[i]));
    done_idx = exp_done_q.size();
    chk({tag, "_err_preamble_pulses"}, 32'(obs_pre_n), 32'(exp_pre_n));
    chk({tag, "_err_length_pulses"}, 32'(obs_len_n), 32'(exp_len_n));
    chk({tag, "_stray"}, 32'(stray_n), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frame_cnt));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err_cnt));
    chk({tag, "_state_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int pre_n, plen, k;
    bit has;
    logic [7:0] sfd;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    chk("rst_out_eof", 32'(out_eof), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("rst_err_preamble", 32'(err_preamble), 32'd0);
    chk("rst_err_length", 32'(err_length), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_last_len", 32'(last_len), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    // Good frame, payload 00..2D.
    repeat (12) drive_sym(1'b1, IDLE_CODE_DEF);
    fill_pattern();
    send_frame(PRE_N, 1'b1, 8'hD5, 46, 0);
    flush("good");
    chk("good_last_len", 32'(last_len), 32'd46);

    // Short preamble, then a good frame.
    fill_random();
    send_frame(6, 1'b1, 8'hD5, 10, 1);
    fill_pattern();
    send_frame(PRE_N, 1'b1, 8'hD5, 46, 0);
    flush("short_pre");

    // Runt.
    send_frame(PRE_N, 1'b1, 8'hD5, 45, 0);
    flush("runt");
    chk("runt_last_len", 32'(last_len), 32'd45);

    // Overflow (70 octets against MAX_D = 64), then a good frame.
    send_frame(PRE_N, 1'b1, 8'hD5, 70, 0);
    send_frame(PRE_N, 1'b1, 8'hD5, 46, 0);
    flush("overflow");

    // Length boundaries: MAX, MAX+1, MIN, zero-length, single octet.
    fill_random();
    send_frame(PRE_N, 1'b1, 8'hD5, MAX_D, 0);
    send_frame(PRE_N, 1'b1, 8'hD5, MAX_D + 1, 0);
    send_frame(PRE_N, 1'b1, 8'hD5, MIN_D, 0);
    flush("bounds");
    send_frame(PRE_N, 1'b1, 8'hD5, 0, 0);
    flush("zero_len");
    chk("zero_len_last_len", 32'(last_len), 32'd0);
    send_frame(PRE_N, 1'b1, 8'hD5, 1, 0);
    flush("one_octet");

    // Preamble faults: long, aborted by control, bad SFD, missing preamble.
    send_frame(PRE_N + 1, 1'b1, 8'hD5, 20, 0);
    send_frame(3, 1'b0, 8'hD5, 0, 0);
    send_frame(PRE_N, 1'b1, 8'hD4, 20, 0);
    send_frame(0, 1'b1, 8'hD5, 5, 0);
    flush("pre_faults");

    // Reset after 10 payload octets: 9 beats already out, then nothing.
    fill_pattern();
    for (int i = 0; i < PRE_N; i++) drive_sym(1'b0, PREAMBLE_CODE_DEF);
    drive_sym(1'b0, SFD_CODE_DEF);
    for (int i = 0; i < 10; i++) drive_sym(1'b0, pay[i]);
    for (int i = 0; i < 9; i++) exp_q.push_back({(i == 0), 1'b0, 1'b0, pay[i]});
    @(negedge clk);
    #2;
    reset = 1'b0;
    rx_ctrl = 1'b1;
    rx_data = 8'h00;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_eof", 32'(out_eof), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_last_len", 32'(last_len), 32'd0);
    m_frame_cnt = 0;
    m_err_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    send_frame(PRE_N, 1'b1, 8'hD5, 46, 0);
    flush("after_reset");

    // Back-to-back: only the end symbol separates the frames.
    send_frame(PRE_N, 1'b1, 8'hD5, 46, 0);
    fill_random();
    send_frame(PRE_N, 1'b1, 8'hD5, 46, 0);
    flush("back_to_back");
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("b2b_err_cnt", 32'(err_cnt), 32'd0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      pre_n = PRE_N;
      has = 1'b1;
      sfd = SFD_CODE_DEF;
      plen = $urandom_range(0, 80);
      if (k == 0) pre_n = $urandom_range(0, 10);
      else if (k == 1) begin
        sfd = 8'($urandom_range(0, 255));
        if (sfd == PREAMBLE_CODE_DEF || sfd == SFD_CODE_DEF) sfd = 8'h5D;
      end else if (k == 2) begin
        has = 1'b0;
        pre_n = $urandom_range(0, 9);
      end else if (k <= 5) plen = $urandom_range(MIN_D - 2, MAX_D + 2);
      fill_random();
      send_frame(pre_n, has, sfd, plen, $urandom_range(0, 3));
      if (n % 4 == 3) flush("rand");
    end
    flush("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mii_frame_checker.md
# mii_frame_checker

Receive-side checker that consumes the byte-wide MII stream produced by the Ethernet frame generator (8-bit data plus control flag). It delineates frames (preamble, SFD, payload, end-of-frame), forwards payload octets as a valid/sof/eof stream, and flags preamble and length errors. Saturating frame and error counters support monitoring. It is the first stage downstream of the generator in the verification/loopback chain.

## Interface
- PREAMBLE_CYCLES, 7, exact number of PREAMBLE_CODE octets required before SFD
- MIN_DATA, 46, minimum legal payload length (octets)
- MAX_DATA, 1500, maximum legal payload length (octets)
- PREAMBLE_CODE, 8'h55, preamble octet
- SFD_CODE, 8'hD5, start-of-frame delimiter octet
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  MII octet
- rx_ctrl  in  1  1 = control/idle/EOF symbol (data ignored), 0 = data octet (preamble, SFD, payload)
- out_data  out  8  payload octet
- out_valid  out  1  out_data valid
- out_sof  out  1  first payload octet of a frame (qualified by out_valid)
- out_eof  out  1  last payload octet of a frame (qualified by out_valid)
- out_err  out  1  frame in error; valid with out_eof
- frame_done  out  1  one-cycle pulse at frame end
- frame_ok  out  1  valid with frame_done: length in [MIN_DATA, MAX_DATA]
- err_preamble  out  1  one-cycle pulse: bad or short/long preamble, or bad SFD
- err_length  out  1  one-cycle pulse: payload too short or too long
- frame_cnt  out  16  good frames, saturating
- err_cnt  out  16  errored frames (preamble or length), saturating
- last_len  out  16  payload length of last completed frame

## Operation
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: rx_ctrl=1 -> stay. rx_ctrl=0 with PREAMBLE_CODE -> PREAMBLE, pre_cnt=1. Any other data octet -> DROP, pulse err_preamble.
- PREAMBLE: PREAMBLE_CODE -> pre_cnt+1, saturating at PREAMBLE_CYCLES+1. SFD_CODE with pre_cnt==PREAMBLE_CYCLES -> DATA, len=0. SFD with any other count -> DROP plus err_preamble. Other data octet -> DROP plus err_preamble. rx_ctrl=1 -> IDLE plus err_preamble.
- DATA, rx_ctrl=0: octet goes into the hold register and len increments. The previously held octet, if any, is emitted with out_valid. out_sof is set on the first emitted octet of the frame.
- DATA, rx_ctrl=1 (end of frame): held octet is emitted with out_eof=1. frame_done pulses. last_len=len. frame_ok=(MIN_DATA<=len<=MAX_DATA). If not ok: out_err=1 and err_length pulses. Next state is IDLE.
- Overflow: in DATA, a data octet arrives with len==MAX_DATA. The held octet (the MAX_DATA-th) is emitted with out_eof=1 and out_err=1. frame_done pulses with frame_ok=0, err_length pulses, and the state goes to DROP.
- Zero-length frame: SFD is followed directly by rx_ctrl=1. No payload beat is emitted. frame_done pulses with frame_ok=0, err_length pulses, and last_len=0.
- DROP: no out_valid. Leaves to IDLE on the first rx_ctrl=1.
- Counters: frame_cnt increments on frame_done with frame_ok=1. err_cnt increments on each err_preamble or err_length pulse (at most +1 per cycle). Both saturate at 16'hFFFF.
- len is 16 bits. It cannot exceed MAX_DATA because overflow is checked before the increment.
- Back-to-back frames: a preamble octet on the cycle right after the end-of-frame control symbol is accepted. No inter-frame gap is enforced.

## Timing
- Reset (reset=0): state=IDLE. All outputs 0, counters 0, hold register empty. A partial frame is discarded with no out_eof and no frame_done.
- All outputs are registered.
- A payload octet sampled at edge k appears on out_data after edge k+1. This holds whether edge k+1 samples another payload octet or the end symbol.
- frame_done, frame_ok, err_length and last_len update in the same cycle as the out_eof beat.
- err_preamble is visible after the edge that samples the offending symbol.
- Counters update one cycle after the corresponding pulse.
- Pulses (frame_done, err_*, out_valid/sof/eof/err) last one cycle and are 0 otherwise.

## Structure
- Shared package mii_pkg:
  - state enum (IDLE, PREAMBLE, DATA, DROP)
  - default code constants: PREAMBLE 8'h55, SFD 8'hD5, IDLE/EOF 8'h00
  - default cycle counts (7, 1, 46)
- Sub-module mii_sat_counter (WIDTH parameter, inc input, saturating count output), instantiated for frame_cnt and err_cnt.

## Test plan
- Good frame: 12 idle, 7x55, D5, 46 payload octets 00..2D, then idle -> 46 out_valid beats; sof on 00; eof on 2D with out_err=0; frame_ok=1; last_len=46; frame_cnt=1; err_cnt=0.
- Short preamble: 6x55 then D5 -> err_preamble pulse, no out_valid, err_cnt=1. The following good frame passes and frame_cnt=1.
- Runt: 45-octet payload -> 45 beats; eof with out_err=1; frame_ok=0; err_length pulse; last_len=45.
- Overflow with MAX_DATA=64, 70 payload octets -> 64 beats; 64th carries eof plus out_err; remaining 6 dropped; the next good frame is received intact.
- Reset mid-frame: reset pulled low after 10 payload octets -> all outputs 0 immediately, no frame_done, counters 0. The next frame is good.
- Back-to-back: two 46-octet frames separated by one idle cycle -> two eof beats, frame_cnt=2, err_cnt=0.
